// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, next-PC select.
// Optional FETCH_FAULT_EN adds a sticky FAULT state (misaligned jr target, imem timeout).
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr_out,
    output logic        imem_req_out,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instr_out,
    output logic [5:0]  opcode_out,
    output logic [5:0]  func_out,
    output logic [4:0]  code_out,
    output logic        instr_valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    input  logic        pc_enable_in,
    input  logic        jmp_mux_select_in,
    input  logic        jmp_immreg_mux_select_in,
    input  logic        brn_mux_select_in,
    input  logic [31:0] jr_target_in,
    output logic        fault_out
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_FAULT} state_t;

    if (IMEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("IMEM_TIMEOUT must be at least 1");
    end

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] next_pc;

`ifdef FETCH_FAULT_EN
    localparam int TMO_W = $clog2(IMEM_TIMEOUT + 1);
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             misaligned;
    assign misaligned = jmp_mux_select_in && !jmp_immreg_mux_select_in && (jr_target_in[1:0] != 2'b00);
`endif

    assign pc_plus4  = pc_q + 32'd4;
    assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jump beats branch; register targets are word-aligned by masking.
    always_comb begin
        next_pc = pc_plus4;
        if (jmp_mux_select_in && jmp_immreg_mux_select_in)
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        else if (jmp_mux_select_in)
            next_pc = jr_target_in & ~32'h0000_0003;
        else if (brn_mux_select_in)
            next_pc = pc_plus4 + br_offset;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
`ifdef FETCH_FAULT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_FAULT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_FAULT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (imem_ready_in) begin
                    instr_d = imem_data_in;
                    state_d = S_EXEC;
                end
`ifdef FETCH_FAULT_EN
                else if (cnt_q == TMO_W'(IMEM_TIMEOUT))
                    state_d = S_FAULT;
                else
                    cnt_d = cnt_q + 1'b1;
`endif
            end
            S_EXEC: begin
                if (pc_enable_in) begin
`ifdef FETCH_FAULT_EN
                    if (misaligned) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                        cnt_d   = '0;
                    end
`else
                    pc_d    = next_pc;
                    state_d = S_FETCH;
`endif
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        imem_req_out    = (state_q == S_FETCH) && !rst;
        instr_valid_out = (state_q == S_EXEC);
`ifdef FETCH_FAULT_EN
        fault_out       = (state_q == S_FAULT);
`else
        fault_out       = 1'b0;
`endif
    end

    assign imem_addr_out = pc_q;
    assign pc_out        = pc_q;
    assign pc_plus4_out  = pc_plus4;
    assign instr_out     = instr_q;
    assign opcode_out    = instr_q[31:26];
    assign func_out      = instr_q[5:0];
    assign code_out      = instr_q[20:16];
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (directed vectors, optional FETCH_FAULT_EN).
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr_out;
    logic        imem_req_out;
    logic        imem_ready_in = 1'b0;
    logic [31:0] imem_data_in = 32'h0;
    logic [31:0] instr_out;
    logic [5:0]  opcode_out;
    logic [5:0]  func_out;
    logic [4:0]  code_out;
    logic        instr_valid_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        pc_enable_in = 1'b0;
    logic        jmp_mux_select_in = 1'b0;
    logic        jmp_immreg_mux_select_in = 1'b0;
    logic        brn_mux_select_in = 1'b0;
    logic [31:0] jr_target_in = 32'h0;
    logic        fault_out;

    fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .imem_addr_out(imem_addr_out), .imem_req_out(imem_req_out),
        .imem_ready_in(imem_ready_in), .imem_data_in(imem_data_in),
        .instr_out(instr_out), .opcode_out(opcode_out), .func_out(func_out),
        .code_out(code_out), .instr_valid_out(instr_valid_out),
        .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
        .pc_enable_in(pc_enable_in), .jmp_mux_select_in(jmp_mux_select_in),
        .jmp_immreg_mux_select_in(jmp_immreg_mux_select_in),
        .brn_mux_select_in(brn_mux_select_in), .jr_target_in(jr_target_in),
        .fault_out(fault_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exec_t;

    logic [31:0] addr_q[$];
    exec_t       exec_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations when the DUT completes a fetch or presents a new instruction.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (imem_req_out && imem_ready_in) begin
                if (addr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL fetch_unexpected: got addr %h expected none", imem_addr_out);
                end else begin
                    chk("fetch_addr", imem_addr_out, addr_q.pop_front());
                end
            end
            if (instr_valid_out && !prev_valid) begin
                if (exec_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL exec_unexpected: got instr %h expected none", instr_out);
                end else begin
                    exec_t e;
                    e = exec_q.pop_front();
                    chk("instr", instr_out, e.instr);
                    chk("pc", pc_out, e.pc);
                    chk("pc_plus4", pc_plus4_out, e.pc + 32'd4);
                    chk("opcode", {26'h0, opcode_out}, {26'h0, e.instr[31:26]});
                    chk("func", {26'h0, func_out}, {26'h0, e.instr[5:0]});
                    chk("code", {27'h0, code_out}, {27'h0, e.instr[20:16]});
                end
            end
            prev_valid <= instr_valid_out;
        end
    end

    // Called one time unit after a rising edge while the DUT is in FETCH.
    task automatic do_instr(input logic [31:0] word, input logic [31:0] pc, input int stall,
                            input logic jmp, input logic immreg, input logic brn,
                            input logic [31:0] jr);
        addr_q.push_back(pc);
        exec_q.push_back('{instr: word, pc: pc});
        imem_ready_in = 1'b1;
        imem_data_in  = word;
        @(posedge clk); #1;
        imem_ready_in = 1'b0;
        imem_data_in  = 32'h0;
        for (int i = 0; i < stall; i++) begin
            pc_enable_in  = 1'b0;
            imem_ready_in = 1'b1;
            imem_data_in  = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            imem_ready_in = 1'b0;
            chk("stall_instr", instr_out, word);
            chk("stall_pc", pc_out, pc);
            chk("stall_valid", {31'h0, instr_valid_out}, 32'h1);
            chk("stall_req", {31'h0, imem_req_out}, 32'h0);
        end
        pc_enable_in             = 1'b1;
        jmp_mux_select_in        = jmp;
        jmp_immreg_mux_select_in = immreg;
        brn_mux_select_in        = brn;
        jr_target_in             = jr;
        @(posedge clk); #1;
        pc_enable_in             = 1'b0;
        jmp_mux_select_in        = 1'b0;
        jmp_immreg_mux_select_in = 1'b0;
        brn_mux_select_in        = 1'b0;
        jr_target_in             = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_valid", {31'h0, instr_valid_out}, 32'h0);
        chk("rst_req", {31'h0, imem_req_out}, 32'h0);
        chk("rst_fault", {31'h0, fault_out}, 32'h0);
        rst = 1'b0;
        #1;
        chk("req_after_rst", {31'h0, imem_req_out}, 32'h1);
        @(posedge clk); #1;

        // Sequential fetches 0,4,8,12,16 then j 0x100
        do_instr(32'h2001_0005, 32'h0000_0000, 0, 0, 0, 0, 32'h0);
        do_instr(32'h0000_0020, 32'h0000_0004, 0, 0, 0, 0, 32'h0);
        do_instr(32'h8C22_0004, 32'h0000_0008, 0, 0, 0, 0, 32'h0);
        do_instr(32'h0000_0000, 32'h0000_000C, 0, 0, 0, 0, 32'h0);
        do_instr(32'h0800_0040, 32'h0000_0010, 0, 1, 1, 0, 32'h0);
        // beq imm=-2 at 0x100 -> 0xFC
        do_instr(32'h1000_FFFE, 32'h0000_0100, 0, 0, 0, 1, 32'h0);
        // jr at 0xFC -> 0x4000_0010
        do_instr(32'h0340_0008, 32'h0000_00FC, 0, 1, 0, 0, 32'h4000_0010);
        // jal with branch also asserted: jump wins -> 0x4000_0100
        do_instr(32'h0C00_0040, 32'h4000_0010, 0, 1, 1, 1, 32'h0);
        // 5-cycle stall with stray ready/data, then advance to 0x4000_0104
        do_instr(32'h0000_0020, 32'h4000_0100, 5, 0, 0, 0, 32'h0);
        // jr to 0x20, then reset mid-fetch with ready low
        do_instr(32'h0340_0008, 32'h4000_0104, 0, 1, 0, 0, 32'h0000_0020);
        @(posedge clk); #1;
        chk("wait_addr", imem_addr_out, 32'h0000_0020);
        chk("wait_req", {31'h0, imem_req_out}, 32'h1);
        #3 rst = 1'b1;
        #1;
        chk("arst_pc", pc_out, 32'h0);
        chk("arst_valid", {31'h0, instr_valid_out}, 32'h0);
        chk("arst_req", {31'h0, imem_req_out}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef FETCH_FAULT_EN
        do_instr(32'h0800_0010, 32'h0000_0000, 0, 1, 1, 0, 32'h0);
        do_instr(32'h0340_0008, 32'h0000_0040, 0, 1, 0, 0, 32'h0000_0102);
        chk("mis_fault", {31'h0, fault_out}, 32'h1);
        chk("mis_req", {31'h0, imem_req_out}, 32'h0);
        chk("mis_valid", {31'h0, instr_valid_out}, 32'h0);
        chk("mis_pc", pc_out, 32'h0000_0040);
        @(posedge clk); #1;
        chk("mis_sticky", {31'h0, fault_out}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 255; i++) begin
            @(posedge clk); #1;
        end
        chk("tmo_255_fault", {31'h0, fault_out}, 32'h0);
        chk("tmo_255_req", {31'h0, imem_req_out}, 32'h1);
        @(posedge clk); #1;
        chk("tmo_256_fault", {31'h0, fault_out}, 32'h1);
        chk("tmo_256_req", {31'h0, imem_req_out}, 32'h0);
        chk("tmo_pc", pc_out, 32'h0);
`else
        // wrap: 0xFFFF_FFFC + 4 -> 0, then misaligned jr masked to 0x100
        do_instr(32'h0340_0008, 32'h0000_0000, 0, 1, 0, 0, 32'hFFFF_FFFC);
        do_instr(32'h0000_0000, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0);
        do_instr(32'h0340_0008, 32'h0000_0000, 0, 1, 0, 0, 32'h0000_0102);
        do_instr(32'h0000_0020, 32'h0000_0100, 0, 0, 0, 0, 32'h0);
        chk("final_addr", imem_addr_out, 32'h0000_0104);
        chk("no_fault", {31'h0, fault_out}, 32'h0);
`endif
        @(posedge clk); #1;
        chk("addr_q_drained", addr_q.size(), 32'h0);
        chk("exec_q_drained", exec_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder (`control`).
- Holds the program counter and issues a request/ready handshake to instruction memory.
- Latches the returned instruction word and splits it into opcode, func and rt-code fields for the decoder.
- Computes the next PC from the decoder's pc_enable, jump and branch selects; multi-cycle, one instruction in flight, no delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_TIMEOUT, 255, max cycles waiting for imem_ready_in before fault. Used only with FETCH_FAULT_EN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- imem_addr_out  output  32  fetch address (current PC)
- imem_req_out  output  1  fetch request
- imem_ready_in  input  1  instruction memory returns imem_data_in this cycle
- imem_data_in  input  32  instruction word
- instr_out  output  32  latched instruction
- opcode_out  output  6  instr_out[31:26]
- func_out  output  6  instr_out[5:0]
- code_out  output  5  instr_out[20:16]
- instr_valid_out  output  1  instr_out is valid for decode/execute
- pc_out  output  32  PC of instr_out
- pc_plus4_out  output  32  pc_out + 4, link address for jal/jalr
- pc_enable_in  input  1  from decoder: commit and advance PC
- jmp_mux_select_in  input  1  from decoder: take jump
- jmp_immreg_mux_select_in  input  1  1 = 26-bit immediate target, 0 = register target
- brn_mux_select_in  input  1  from decoder: branch condition taken
- jr_target_in  input  32  rs register value for jr/jalr
- fault_out  output  1  fetch fault; tied 0 without FETCH_FAULT_EN

Behaviour:
- Reset (async, rst=1):
  - state=FETCH, pc_out=RESET_PC, instr_out=32'h0 (nop), instr_valid_out=0, imem_req_out=0, fault_out=0.
  - imem_req_out rises combinationally from state on the first cycle after rst deasserts.
- States:
  - FETCH: imem_req_out=1, imem_addr_out=pc_out. On imem_ready_in=1: instr_out<=imem_data_in, go EXEC. Otherwise stay.
  - EXEC: instr_valid_out=1, imem_req_out=0. If pc_enable_in=1: pc_out<=next_pc, go FETCH. Else hold in EXEC with instr_out/pc_out stable (stall).
  - FAULT (macro only): imem_req_out=0, instr_valid_out=0, fault_out=1. Sticky until rst.
- next_pc priority:
  1. jmp_mux_select_in=1 and jmp_immreg_mux_select_in=1: {pc_plus4_out[31:28], instr_out[25:0], 2'b00}
  2. jmp_mux_select_in=1 and jmp_immreg_mux_select_in=0: jr_target_in
  3. brn_mux_select_in=1: pc_plus4_out + ({{14{instr_out[15]}}, instr_out[15:0], 2'b00})
  4. otherwise pc_plus4_out
- Jump has priority if jmp and brn are both 1.
- Arithmetic: 32-bit, wrap-around modulo 2^32. PC 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- Selects are sampled only in EXEC on the pc_enable_in cycle; ignored elsewhere.
- Minimum cycles per instruction = 2 (FETCH with ready in same cycle, then EXEC).
- imem_ready_in outside FETCH is ignored; data is not latched.
- rst mid-fetch or mid-EXEC aborts immediately; no partial PC update.
- Misaligned register target without macro: bits [1:0] forced to 2'b00.

Optional Feature:
- Macro: FETCH_FAULT_EN
- With the macro, EXEC enters FAULT instead of FETCH when either:
  - the register-target jump has jr_target_in[1:0]!=0, or
  - FETCH waits more than IMEM_TIMEOUT consecutive cycles without imem_ready_in.
- The timeout counter clears on each FETCH entry.
- pc_out holds the faulting instruction's PC.
- Without the macro: no FAULT state, no counter, fault_out=0, misaligned targets are masked.

Test Plan:
- Reset release, imem_ready_in tied 1, pc_enable_in=1, no jump/branch → imem_addr_out sequence 0,4,8,12 on successive FETCH cycles; instr_valid_out alternates 0/1.
- At pc=0x100, instr_out=0x1000FFFE (beq, imm=-2), brn_mux_select_in=1 → next imem_addr_out=0x0FC.
- At pc=0x4000_0010, instr_out=0x0C00_0040 (jal), jmp=1, immreg=1 → next fetch 0x4000_0100; pc_plus4_out=0x4000_0014 during EXEC.
- In EXEC hold pc_enable_in=0 for 5 cycles → instr_out, pc_out and instr_valid_out=1 stable, imem_req_out=0; PC advances on the 6th cycle when pc_enable_in=1.
- rst asserted in FETCH with imem_ready_in=0 at pc=0x20 → pc_out=RESET_PC and instr_valid_out=0 immediately (async).
- FETCH_FAULT_EN: jr with jr_target_in=0x0000_0102 → fault_out=1, imem_req_out=0, pc_out unchanged. Separately, imem_ready_in=0 for 256 cycles → FAULT.
